// File: rtl/npc_pkg.sv
// Shared decode types: instruction format enum, base opcodes and the XLEN-independent
// part of the decoded bundle.
package npc_pkg;

    typedef enum logic [2:0] {
        InstI   = 3'd0,
        InstU   = 3'd1,
        InstS   = 3'd2,
        InstB   = 3'd3,
        InstJ   = 3'd4,
        InstR   = 3'd5,
        InstBad = 3'd7
    } inst_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // XLEN-wide pc/imm are appended by idu_pipe, which knows XLEN.
    typedef struct packed {
        logic [6:0] op;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        inst_type_e inst_type;
        logic       illegal;
    } dec_bundle_t;

endpackage

// File: rtl/idu_decode.sv
// Combinational RV decode: raw fields, immediate format from opcode, sign-extended
// immediate and illegal flag.
module idu_decode
    import npc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output dec_bundle_t     o_dec,
    output logic [XLEN-1:0] o_imm
);

    inst_type_e  w_type;
    logic [31:0] w_imm32;

    always_comb begin
        w_type = InstBad;
        if (i_inst[1:0] == 2'b11) begin
            case (i_inst[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: w_type = InstI;
                OPC_LUI, OPC_AUIPC:                         w_type = InstU;
                OPC_STORE:                                  w_type = InstS;
                OPC_BRANCH:                                 w_type = InstB;
                OPC_JAL:                                    w_type = InstJ;
                OPC_OP:                                     w_type = InstR;
                OPC_OP_IMM_32: if (XLEN == 64)              w_type = InstI;
                OPC_OP_32:     if (XLEN == 64)              w_type = InstR;
                default:                                    w_type = InstBad;
            endcase
        end
    end

    always_comb begin
        w_imm32 = 32'h0;
        case (w_type)
            InstI: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            InstU: w_imm32 = {i_inst[31:12], 12'h000};
            InstS: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            InstB: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                              i_inst[11:8], 1'b0};
            InstJ: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                              i_inst[30:21], 1'b0};
            default: w_imm32 = 32'h0;
        endcase
    end

    // Every format's immediate fits in 32 bits; widening repeats bit 31.
    assign o_imm = XLEN'($signed(w_imm32));

    assign o_dec.op        = i_inst[6:0];
    assign o_dec.func3     = i_inst[14:12];
    assign o_dec.func7     = i_inst[31:25];
    assign o_dec.rd        = i_inst[11:7];
    assign o_dec.rs1       = i_inst[19:15];
    assign o_dec.rs2       = i_inst[24:20];
    assign o_dec.inst_type = w_type;
    assign o_dec.illegal   = (w_type == InstBad);

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage between IFU and EXU: valid/ready in and out, optional skid
// entry, flush on redirect.
module idu_pipe
    import npc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SKID = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_inst,
    input  logic [XLEN-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_pc,
    output logic [6:0]      o_op,
    output logic [2:0]      o_func3,
    output logic [6:0]      o_func7,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_inst_type,
    output logic            o_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_bundle_t     dec;
    } entry_t;

    dec_bundle_t     w_dec;
    logic [XLEN-1:0] w_imm;
    entry_t          w_in_entry;

    entry_t r_out, r_skid, w_out_nxt, w_skid_nxt;
    logic   r_out_valid, r_skid_valid, w_out_valid_nxt, w_skid_valid_nxt;
    logic   r_ready, w_ready_nxt;
    logic   w_out_free, w_accept;

    idu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_inst (i_in_inst),
        .o_dec  (w_dec),
        .o_imm  (w_imm)
    );

    assign w_in_entry = '{pc: i_in_pc, imm: w_imm, dec: w_dec};

    // r_ready is low only in reset; with a skid it also tracks "skid entry empty".
    assign w_out_free = !r_out_valid || i_out_ready;
    assign o_in_ready = (SKID != 0) ? r_ready : (r_ready && w_out_free);
    assign w_accept   = i_in_valid && o_in_ready;

    always_comb begin
        w_out_nxt        = r_out;
        w_out_valid_nxt  = r_out_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (i_flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid is older than anything at the input; in_ready is low while it holds.
                w_out_nxt        = r_skid;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else begin
                w_out_valid_nxt = w_accept;
                if (w_accept) begin
                    w_out_nxt = w_in_entry;
                end
            end
        end else if ((SKID != 0) && w_accept) begin
            w_skid_nxt       = w_in_entry;
            w_skid_valid_nxt = 1'b1;
        end
        w_ready_nxt = (SKID != 0) ? !w_skid_valid_nxt : 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_out        <= w_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_pc    = r_out.pc;
    assign o_imm       = r_out.imm;
    assign o_op        = r_out.dec.op;
    assign o_func3     = r_out.dec.func3;
    assign o_func7     = r_out.dec.func7;
    assign o_rd        = r_out.dec.rd;
    assign o_rs1       = r_out.dec.rs1;
    assign o_rs2       = r_out.dec.rs2;
    assign o_inst_type = r_out.dec.inst_type;
    assign o_illegal   = r_out.dec.illegal;

endmodule

// File: doc/idu_pipe.md
# idu_pipe

Registered, parametrised instruction-decode stage between the IFU and EXU. It takes a fetched instruction and PC over a valid/ready handshake and derives the immediate format from the opcode; no external type input is needed. It presents the decoded fields, an XLEN-wide sign-extended immediate and an illegal-instruction flag one cycle later. It supports pipeline back-pressure, an optional skid buffer, and flush on redirect.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64. At 64, OP-IMM-32/OP-32 are also legal.
- `SKID`, default 0: 0 is a single pipeline register with combinational `in_ready`; 1 adds a second entry and registers `in_ready`.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: drop all held and incoming instructions.
- `in_valid`, in, 1: upstream offers `in_inst`/`in_pc`.
- `in_ready`, out, 1: stage accepts this cycle.
- `in_inst`, in, 32: raw instruction.
- `in_pc`, in, XLEN: instruction PC.
- `out_valid`, out, 1: decoded bundle valid.
- `out_ready`, in, 1: downstream accepts.
- `out_pc`, out, XLEN: PC passed through.
- `op`, out, 7: `inst[6:0]`.
- `func3`, out, 3: `inst[14:12]`.
- `func7`, out, 7: `inst[31:25]`.
- `rd`, `rs1`, `rs2`, out, 5 each: register indices.
- `imm`, out, XLEN: sign-extended immediate.
- `inst_type`, out, 3: I=0, U=1, S=2, B=3, J=4, R=5, BAD=7.
- `illegal`, out, 1: opcode not recognised, or `inst[1:0]` ≠ 2'b11.

## Operation
- Type from opcode:
  - 0000011, 0010011, 1100111, 1110011 → I.
  - 0110111, 0010111 → U.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110011 → R.
  - XLEN=64 only: 0011011 → I and 0111011 → R.
  - Anything else → BAD with `illegal`=1.
- Immediates, sign-extended from `inst[31]` to XLEN:
  - I = inst[31:20].
  - U = {inst[31:12], 12'b0}, extended above bit 31 when XLEN=64.
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and BAD give `imm`=0.
- Field outputs (`rd`, `rs1`, `rs2`, `func3`, `func7`, `op`) are raw slices regardless of type.
- Decode happens on the input side. The registered bundle is what the outputs show.
- Illegal instructions still flow downstream with `illegal`=1. They are never dropped.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `out_valid`=0, all data outputs 0, `inst_type`=0, `illegal`=0.
  - `in_ready`=0 while `rst_n` is low.
  - `in_ready`=1 from the first cycle after release.
- Transfer occurs when valid && ready on the same rising edge.
- Latency is 1 cycle from input acceptance to `out_valid`.
- SKID=0:
  - `in_ready` = !out_valid || out_ready.
  - Throughput is one per cycle under continuous `out_ready`.
- SKID=1:
  - `in_ready` is a flop, equal to "skid entry empty".
  - When `out_ready` drops, one extra in-flight instruction is captured in the skid entry.
  - The skid entry drains into the output register first. FIFO order is preserved.
  - Full with both entries holding: `in_ready`=0. It returns to 1 the cycle after the skid entry drains.
- While `out_valid`=1 && `out_ready`=0, all outputs stay stable.
- `flush`:
  - On the next edge, all entries are invalidated and `out_valid`=0.
  - An input handshaking in the flush cycle is discarded.
  - `flush` has priority over a simultaneous output handshake; that output is still considered consumed by downstream.
  - `in_ready` is 1 the cycle after.
- Reset asserted mid-transfer clears all state immediately. No bundle survives.

## Structure
- Shared package `npc_pkg`:
  - `inst_type_e` enum.
  - Opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_SYSTEM, OPC_OP_IMM_32, OPC_OP_32).
  - Packed struct `dec_bundle_t`, parametrised by XLEN through the module.
- Sub-module `idu_decode` (combinational: inst → type, imm, illegal, fields).
- `idu_pipe` holds the register/skid handshake only.

## Test plan
- XLEN=32, `in_inst`=0xFFF00093 (addi x1,x0,-1) → next cycle: `out_valid`=1, type I, `rd`=1, `rs1`=0, `imm`=0xFFFFFFFF, `illegal`=0.
- `in_inst`=0x00112623 (sw x1,12(x2)) → type S, `imm`=12, `rs1`=2, `rs2`=1. Then 0xFFDFF0EF (jal x1,-4) → type J, `imm`=0xFFFFFFFC.
- XLEN=64, `in_inst`=0x800002B7 (lui x5,0x80000) → type U, `imm`=0xFFFFFFFF80000000. Then 0x0010009B (addiw) → type I, `illegal`=0. The same word at XLEN=32 → type BAD, `illegal`=1.
- `in_inst`=0x00000000 → type BAD, `illegal`=1, `imm`=0, and the bundle is still delivered.
- SKID=1: stream 4 instructions, hold `out_ready`=0 for 3 cycles → exactly 2 held, `in_ready`=0. Release → the 4 appear in order, no duplicates or loss.
- Assert `flush` with `out_valid`=1 and an input handshake in the same cycle → next cycle `out_valid`=0 and the flushed input never appears. Pulse `rst_n` low mid-stream → outputs 0 immediately.
